mux_arb_reg: RTL and testbench

Parametrised N-to-1 datapath selector with a registered output stage and valid/ready handshakes on every channel, successor to the fixed 16:1 32-bit combinational mux. Selects a source either from an explicit select input or by round-robin among requesting channels. Sits between multiple producers (register file ports, ALU, memory return, immediates) and a single consumer stage, adding one pipeline register and back-pressure.

---
 rtl/mux_arb_pkg.sv | 10 +
 rtl/mux_arb_reg_rr_grant.sv | 39 +++
 rtl/mux_arb_reg.sv | 138 +++++++++++++
 tb/tb_mux_arb_reg.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/mux_arb_pkg.sv
// Shared constants for the mux_arb_reg selector: mode encodings and default sizing.
package mux_arb_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_N     = 16;

endpackage

// File: rtl/mux_arb_reg_rr_grant.sv
// rr_grant: rotating priority encoder. The first requester at or after ptr wins, wrapping modulo N.
module rr_grant
    import mux_arb_pkg::*;
#(
    parameter int N = DEF_N
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [$clog2(N)-1:0] grant,
    output logic                 grant_valid
);

    localparam int SEL_W = $clog2(N);

    int idx_s;

    // Scan offsets from far to near so the requester nearest to ptr is written last and wins.
    always_comb begin
        grant       = '0;
        grant_valid = 1'b0;
        idx_s       = 0;
        for (int k = N - 1; k >= 0; k--) begin
            idx_s = int'(ptr) + k;
            // The wrap is explicit because N need not be a power of two.
            if (idx_s >= N) begin
                idx_s = idx_s - N;
            end else begin
                idx_s = idx_s;
            end
            if (req[idx_s[SEL_W-1:0]]) begin
                grant       = idx_s[SEL_W-1:0];
                grant_valid = 1'b1;
            end else begin
                grant_valid = grant_valid;
            end
        end
    end

endmodule

// File: rtl/mux_arb_reg.sv
// mux_arb_reg: N-to-1 valid/ready selector with a registered output stage.
// Round-robin mode is compiled in only when MUX_ARB_RR_EN is defined; otherwise mode is ignored.
module mux_arb_reg
    import mux_arb_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int N     = DEF_N
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   mode,
    input  logic [$clog2(N)-1:0]   sel,
    input  logic [N*WIDTH-1:0]     in_data,
    input  logic [N-1:0]           in_valid,
    output logic [N-1:0]           in_ready,
    output logic [WIDTH-1:0]       out_data,
    output logic [$clog2(N)-1:0]   out_chan,
    output logic                   out_valid,
    input  logic                   out_ready
);

    localparam int SEL_W = $clog2(N);

    logic [WIDTH-1:0] chan_data_s [N];
    logic             free_s;
    logic             sel_ok_s;
    logic             fix_valid_s;
    logic [SEL_W-1:0] grant_s;
    logic             grant_valid_s;
    logic             xfer_s;
    logic [WIDTH-1:0] out_data_r;
    logic [SEL_W-1:0] out_chan_r;
    logic             out_valid_r;

    for (genvar i = 0; i < N; i++) begin : g_unpack
        assign chan_data_s[i] = in_data[i*WIDTH +: WIDTH];
    end

    assign free_s = !out_valid_r || out_ready;

    // Fixed-select candidate; an out-of-range sel never grants.
    always_comb begin
        sel_ok_s    = (32'(sel) < 32'(N));
        fix_valid_s = 1'b0;
        if (sel_ok_s) begin
            fix_valid_s = in_valid[sel];
        end else begin
            fix_valid_s = 1'b0;
        end
    end

`ifdef MUX_ARB_RR_EN
    logic [SEL_W-1:0] ptr_r;
    logic [SEL_W-1:0] rr_grant_s;
    logic             rr_valid_s;
    logic             mode_rr_s;

    rr_grant #(.N(N)) u_rr_grant (
        .req         (in_valid),
        .ptr         (ptr_r),
        .grant       (rr_grant_s),
        .grant_valid (rr_valid_s)
    );

    assign mode_rr_s = (mode == MODE_RR);

    // Grant source follows mode in the same cycle.
    always_comb begin
        grant_s       = '0;
        grant_valid_s = 1'b0;
        if (mode_rr_s) begin
            grant_s       = rr_grant_s;
            grant_valid_s = rr_valid_s;
        end else begin
            grant_s       = sel;
            grant_valid_s = fix_valid_s;
        end
    end

    // Pointer moves past the winner only on round-robin transfers; kept across mode changes.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ptr_r <= '0;
        end else if (xfer_s && mode_rr_s) begin
            if (grant_s == SEL_W'(N - 1)) begin
                ptr_r <= '0;
            end else begin
                ptr_r <= grant_s + 1'b1;
            end
        end else begin
            ptr_r <= ptr_r;
        end
    end
`else
    logic unused_mode_s;
    assign unused_mode_s = mode;

    // Without round-robin support the block is always a fixed selector.
    always_comb begin
        grant_s       = sel;
        grant_valid_s = fix_valid_s;
    end
`endif

    assign xfer_s = grant_valid_s && free_s && reset_n;

    // Only the granted channel sees ready, and nothing is ready while held in reset.
    always_comb begin
        in_ready = '0;
        if (grant_valid_s && reset_n) begin
            in_ready[grant_s] = free_s;
        end else begin
            in_ready = '0;
        end
    end

    // Output stage: load on transfer, drain when free and idle, otherwise hold.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            out_data_r  <= '0;
            out_chan_r  <= '0;
            out_valid_r <= 1'b0;
        end else if (xfer_s) begin
            out_data_r  <= chan_data_s[grant_s];
            out_chan_r  <= grant_s;
            out_valid_r <= 1'b1;
        end else if (free_s) begin
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= out_valid_r;
        end
    end

    assign out_data  = out_data_r;
    assign out_chan  = out_chan_r;
    assign out_valid = out_valid_r;

endmodule

// File: tb/tb_mux_arb_reg.sv
// Directed self-checking bench for mux_arb_reg (N=16 and N=5 instances); round-robin steps need MUX_ARB_RR_EN.
module tb_mux_arb_reg;

    logic          clk;
    logic          reset_n;

    logic          mode;
    logic [3:0]    sel;
    logic [511:0]  in_data;
    logic [15:0]   in_valid;
    logic [15:0]   in_ready;
    logic [31:0]   out_data;
    logic [3:0]    out_chan;
    logic          out_valid;
    logic          out_ready;

    logic          mode5;
    logic [2:0]    sel5;
    logic [159:0]  in_data5;
    logic [4:0]    in_valid5;
    logic [4:0]    in_ready5;
    logic [31:0]   out_data5;
    logic [2:0]    out_chan5;
    logic          out_valid5;
    logic          out_ready5;

    int checks   = 0;
    int failures = 0;

    mux_arb_reg #(.WIDTH(32), .N(16)) u_dut (
        .clk(clk), .reset_n(reset_n), .mode(mode), .sel(sel),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_chan(out_chan), .out_valid(out_valid),
        .out_ready(out_ready)
    );

    mux_arb_reg #(.WIDTH(32), .N(5)) u_dut5 (
        .clk(clk), .reset_n(reset_n), .mode(mode5), .sel(sel5),
        .in_data(in_data5), .in_valid(in_valid5), .in_ready(in_ready5),
        .out_data(out_data5), .out_chan(out_chan5), .out_valid(out_valid5),
        .out_ready(out_ready5)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n    = 1'b0;
        mode       = 1'b0;
        sel        = 4'd5;
        in_valid   = 16'hFFFF;
        out_ready  = 1'b1;
        mode5      = 1'b0;
        sel5       = 3'd0;
        in_valid5  = 5'h00;
        out_ready5 = 1'b1;
        for (int i = 0; i < 16; i++) in_data[i*32 +: 32] = 32'h1000_0000 + 32'(i);
        for (int i = 0; i < 5; i++) in_data5[i*32 +: 32] = 32'h5500_0000 + 32'(i);
        in_data[5*32 +: 32] = 32'hDEADBEEF;

        // Reset with every channel requesting.
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'h0);
        step();
        step();
        chk("rst_out_valid", 64'(out_valid), 64'h0);
        chk("rst_out_data", 64'(out_data), 64'h0);
        chk("rst_out_chan", 64'(out_chan), 64'h0);
        chk("rst_in_ready_held", 64'(in_ready), 64'h0);

        // Fixed select of channel 5.
        reset_n = 1'b1;
        #1;
        chk("fix_in_ready", 64'(in_ready), 64'h0020);
        step();
        chk("fix_out_valid", 64'(out_valid), 64'h1);
        chk("fix_out_data", 64'(out_data), 64'hDEADBEEF);
        chk("fix_out_chan", 64'(out_chan), 64'h5);

        // Selected channel idle: no grant and the register drains.
        sel      = 4'd3;
        in_valid = 16'hFFF7;
        #1;
        chk("idle_in_ready", 64'(in_ready), 64'h0);
        step();
        chk("idle_out_valid", 64'(out_valid), 64'h0);

        // Back-pressure on channel 7.
        sel      = 4'd7;
        in_valid = 16'h0080;
        in_data[7*32 +: 32] = 32'hA7A7_0001;
        #1;
        chk("bp_first_ready", 64'(in_ready), 64'h0080);
        step();
        chk("bp_first_data", 64'(out_data), 64'hA7A7_0001);
        in_data[7*32 +: 32] = 32'hB7B7_0002;
        out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("bp_stall_ready", 64'(in_ready), 64'h0);
            step();
            chk("bp_stall_valid", 64'(out_valid), 64'h1);
            chk("bp_stall_data", 64'(out_data), 64'hA7A7_0001);
            chk("bp_stall_chan", 64'(out_chan), 64'h7);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_ready", 64'(in_ready), 64'h0080);
        step();
        chk("bp_release_valid", 64'(out_valid), 64'h1);
        chk("bp_release_data", 64'(out_data), 64'hB7B7_0002);

        // Select change takes effect in the same cycle.
        in_valid = 16'hFFFF;
        sel      = 4'd9;
        #1;
        chk("sel9_in_ready", 64'(in_ready), 64'h0200);
`ifndef MUX_ARB_RR_EN
        mode = 1'b1;
        #1;
        chk("mode_ignored_ready", 64'(in_ready), 64'h0200);
`endif
        step();
        chk("sel9_out_chan", 64'(out_chan), 64'h9);
        chk("sel9_out_data", 64'(out_data), 64'h1000_0009);
        mode = 1'b0;

        // Reset while a stalled beat is held discards it.
        out_ready = 1'b0;
        reset_n   = 1'b0;
        #1;
        chk("midrst_in_ready", 64'(in_ready), 64'h0);
        step();
        chk("midrst_out_valid", 64'(out_valid), 64'h0);
        chk("midrst_out_data", 64'(out_data), 64'h0);
        reset_n   = 1'b1;
        out_ready = 1'b1;

        // N=5 instance: out-of-range selects never grant, sel 4 does.
        in_valid5 = 5'h1F;
        sel5      = 3'd6;
        #1;
        chk("n5_sel6_ready", 64'(in_ready5), 64'h0);
        sel5 = 3'd5;
        #1;
        chk("n5_sel5_ready", 64'(in_ready5), 64'h0);
        step();
        chk("n5_sel5_valid", 64'(out_valid5), 64'h0);
        sel5 = 3'd4;
        #1;
        chk("n5_sel4_ready", 64'(in_ready5), 64'h10);
        step();
        chk("n5_sel4_chan", 64'(out_chan5), 64'h4);
        chk("n5_sel4_data", 64'(out_data5), 64'h5500_0004);

`ifdef MUX_ARB_RR_EN
        // Round-robin between channels 2 and 14, ptr wrapping 15 -> 0.
        reset_n = 1'b0;
        step();
        reset_n  = 1'b1;
        mode     = 1'b1;
        in_valid = 16'h4004;
        for (int r = 0; r < 4; r++) begin
            #1;
            chk("rr_wrap_ready", 64'(in_ready), (r % 2 == 0) ? 64'h0004 : 64'h4000);
            step();
            chk("rr_wrap_chan", 64'(out_chan), (r % 2 == 0) ? 64'd2 : 64'd14);
            chk("rr_wrap_valid", 64'(out_valid), 64'h1);
        end

        // Park ptr at 9, then reset mid-stream.
        in_valid = 16'h0100;
        step();
        chk("rr_ptr9_chan", 64'(out_chan), 64'd8);
        in_valid = 16'hFFFF;
        #1;
        chk("rr_ptr9_ready", 64'(in_ready), 64'h0200);
        reset_n = 1'b0;
        #1;
        chk("rr_rst_ready", 64'(in_ready), 64'h0);
        step();
        chk("rr_rst_valid", 64'(out_valid), 64'h0);
        reset_n = 1'b1;
        #1;
        chk("rr_after_rst_ready", 64'(in_ready), 64'h0001);
        step();
        chk("rr_after_rst_chan", 64'(out_chan), 64'd0);

        // Mode-0 transfer leaves ptr alone.
        mode = 1'b0;
        sel  = 4'd3;
        #1;
        chk("rr_to_fix_ready", 64'(in_ready), 64'h0008);
        step();
        mode = 1'b1;
        #1;
        chk("rr_ptr_kept_ready", 64'(in_ready), 64'h0002);
        step();
        chk("rr_ptr_kept_chan", 64'(out_chan), 64'd1);

        // N=5 round-robin wraps explicitly: 0,1,2,3,4,0.
        reset_n = 1'b0;
        step();
        reset_n   = 1'b1;
        mode5     = 1'b1;
        in_valid5 = 5'h1F;
        for (int k = 0; k < 6; k++) begin
            #1;
            chk("n5_rr_ready", 64'(in_ready5), 64'(5'b00001 << (k % 5)));
            step();
            chk("n5_rr_chan", 64'(out_chan5), 64'(k % 5));
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
